// File: rtl/svpwm_scheduler.sv
// svpwm_scheduler: centre-aligned carrier timer and duty update sequencer for SVPWM.
// Accepts (da_on, db_on, dc_on) triples over a valid/ready handshake into a pending
// buffer. The pending triple is promoted to active at the carrier valley. Each phase
// is compared against the carrier and drives a complementary gate pair with dead-time.
//
// Optional feature: define SVPWM_DOUBLE_UPDATE_EN to make the carrier peak an update
// point too, giving two updates per period.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   en                         run enable
//   da_on, db_on, dc_on        per-phase duty, CMAX = 100%
//   duty_valid / duty_ready    handshake; ready means the pending buffer is empty
//   pwm_{a,b,c}{h,l}           high/low gate drives
//   period_start               one-cycle pulse registered from each update point
//   update_miss                one-cycle pulse at an update point with pending empty
module svpwm_scheduler #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEAD  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] da_on,
   input  logic [WIDTH-1:0] db_on,
   input  logic [WIDTH-1:0] dc_on,
   input  logic             duty_valid,
   output logic             duty_ready,
   output logic             pwm_ah,
   output logic             pwm_al,
   output logic             pwm_bh,
   output logic             pwm_bl,
   output logic             pwm_ch,
   output logic             pwm_cl,
   output logic             period_start,
   output logic             update_miss
);

   localparam logic [WIDTH-1:0] CMAX    = {WIDTH{1'b1}};
   localparam int unsigned      DTW     = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
   localparam int unsigned      NPH     = 3;
   localparam bit               DT_ZERO = (DEAD == 0);

   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

   dir_e                        dir_q, dir_d;
   logic [WIDTH-1:0]            cnt_q, cnt_d;
   logic [NPH-1:0][WIDTH-1:0]   act_q, act_d, pend_q, pend_d, duty_in_c;
   logic                        pend_empty_q, pend_empty_d;
   logic                        run_q;
   logic [NPH-1:0]              ref_q, ref_d, tgt_q, tgt_d, hi_q, hi_d, lo_q, lo_d;
   logic [NPH-1:0][DTW-1:0]     dt_q, dt_d;
   logic                        ps_q, ps_d, miss_q, miss_d;
   logic                        upd_c, take_c;

   assign duty_in_c = {dc_on, db_on, da_on};
   assign take_c    = duty_valid && pend_empty_q;

`ifdef SVPWM_DOUBLE_UPDATE_EN
   assign upd_c = en && ((cnt_q == '0) || (cnt_q == CMAX));
`else
   assign upd_c = en && (cnt_q == '0);
`endif

   // Carrier: up/down counter, direction is the state.
   always_comb begin
      cnt_d = cnt_q;
      dir_d = dir_q;
      if (!en) begin
         cnt_d = '0;
         dir_d = DIR_UP;
      end else begin
         unique case (dir_q)
            DIR_UP: begin
               if (cnt_q == CMAX) begin
                  cnt_d = CMAX - WIDTH'(1);
                  dir_d = DIR_DOWN;
               end else begin
                  cnt_d = cnt_q + WIDTH'(1);
               end
            end
            DIR_DOWN: begin
               if (cnt_q == '0) begin
                  cnt_d = WIDTH'(1);
                  dir_d = DIR_UP;
               end else begin
                  cnt_d = cnt_q - WIDTH'(1);
               end
            end
            default: begin
               cnt_d = '0;
               dir_d = DIR_UP;
            end
         endcase
      end
   end

   // Double buffer and update-point pulses. A take can only happen while pending is
   // empty, so it never collides with a promotion in the same cycle.
   always_comb begin
      act_d        = act_q;
      pend_d       = pend_q;
      pend_empty_d = pend_empty_q;
      ps_d         = upd_c;
      miss_d       = 1'b0;
      if (upd_c) begin
         if (!pend_empty_q) begin
            act_d        = pend_q;
            pend_empty_d = 1'b1;
         end else begin
            miss_d = 1'b1;
         end
      end
      if (take_c) begin
         pend_d       = duty_in_c;
         pend_empty_d = 1'b0;
      end
   end

   // Compare and dead-time. A start-up (first enabled cycle) counts as a move toward
   // whatever side ref currently holds, so gates always pass through the dead window.
   always_comb begin
      ref_d = ref_q;
      tgt_d = tgt_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      dt_d  = dt_q;
      for (int unsigned i = 0; i < NPH; i++) begin
         if (!en) begin
            ref_d[i] = 1'b0;
            tgt_d[i] = 1'b0;
            hi_d[i]  = 1'b0;
            lo_d[i]  = 1'b0;
            dt_d[i]  = '0;
         end else begin
            ref_d[i] = act_q[i] > cnt_q;
            if (!run_q || (ref_q[i] != tgt_q[i])) begin
               tgt_d[i] = ref_q[i];
               if (DT_ZERO) begin
                  hi_d[i] = ref_q[i];
                  lo_d[i] = !ref_q[i];
                  dt_d[i] = '0;
               end else begin
                  hi_d[i] = 1'b0;
                  lo_d[i] = 1'b0;
                  dt_d[i] = DTW'(DEAD);
               end
            end else if (dt_q[i] != '0) begin
               dt_d[i] = dt_q[i] - DTW'(1);
               if (dt_q[i] == DTW'(1)) begin
                  hi_d[i] = tgt_q[i];
                  lo_d[i] = !tgt_q[i];
               end
            end
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q        <= DIR_UP;
         cnt_q        <= '0;
         act_q        <= '0;
         pend_q       <= '0;
         pend_empty_q <= 1'b1;
         run_q        <= 1'b0;
         ref_q        <= '0;
         tgt_q        <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         dt_q         <= '0;
         ps_q         <= 1'b0;
         miss_q       <= 1'b0;
      end else begin
         dir_q        <= dir_d;
         cnt_q        <= cnt_d;
         act_q        <= act_d;
         pend_q       <= pend_d;
         pend_empty_q <= pend_empty_d;
         run_q        <= en;
         ref_q        <= ref_d;
         tgt_q        <= tgt_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         dt_q         <= dt_d;
         ps_q         <= ps_d;
         miss_q       <= miss_d;
      end
   end

   assign duty_ready   = pend_empty_q;
   assign pwm_ah       = hi_q[0];
   assign pwm_al       = lo_q[0];
   assign pwm_bh       = hi_q[1];
   assign pwm_bl       = lo_q[1];
   assign pwm_ch       = hi_q[2];
   assign pwm_cl       = lo_q[2];
   assign period_start = ps_q;
   assign update_miss  = miss_q;

endmodule

// File: tb/tb_svpwm_scheduler.sv
// Directed testbench for svpwm_scheduler at WIDTH=8, DEAD=4.
// Cycle naming below: En is the n-th rising edge that samples en=1 after enabling;
// outputs are observed 1 time unit after each edge.
module tb_svpwm_scheduler;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEAD  = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic [WIDTH-1:0] da_on, db_on, dc_on;
   logic             duty_valid;
   logic             duty_ready;
   logic             pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl;
   logic             period_start, update_miss;
   logic [5:0]       g;

   int total = 0;
   int bad   = 0;
   int hi_cnt[6];
   int overlap;
   int n;
   bit ready_low;

   svpwm_scheduler #(.WIDTH(WIDTH), .DEAD(DEAD)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .da_on        (da_on),
      .db_on        (db_on),
      .dc_on        (dc_on),
      .duty_valid   (duty_valid),
      .duty_ready   (duty_ready),
      .pwm_ah       (pwm_ah),
      .pwm_al       (pwm_al),
      .pwm_bh       (pwm_bh),
      .pwm_bl       (pwm_bl),
      .pwm_ch       (pwm_ch),
      .pwm_cl       (pwm_cl),
      .period_start (period_start),
      .update_miss  (update_miss)
   );

   always #5 clk = ~clk;

   // g[5]=ah g[4]=al g[3]=bh g[2]=bl g[1]=ch g[0]=cl
   assign g = {pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until period_start is seen, bounded; n returns the ticks taken.
   task automatic wait_ps(input string tag, output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (period_start !== 1'b1 && cnt < 600);
      chk(tag, 32'(period_start), 32'd1);
   endtask

   // Count gate-high samples over 510 consecutive cycles (one carrier period).
   task automatic measure();
      for (int k = 0; k < 6; k++) hi_cnt[k] = 0;
      overlap = 0;
      for (int s = 0; s < 510; s++) begin
         tick();
         for (int k = 0; k < 6; k++) if (g[k]) hi_cnt[k]++;
         if ((pwm_ah && pwm_al) || (pwm_bh && pwm_bl) || (pwm_ch && pwm_cl)) overlap++;
      end
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      da_on = a; db_on = b; dc_on = c;
      duty_valid = 1'b1;
      tick();
      duty_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; duty_valid = 1'b0;
      da_on = '0; db_on = '0; dc_on = '0;
      repeat (3) tick();
      chk("rst_gates", 32'(g), 32'd0);
      chk("rst_ready", 32'(duty_ready), 32'd1);
      chk("rst_ps", 32'(period_start), 32'd0);
      chk("rst_miss", 32'(update_miss), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_gates", 32'(g), 32'd0);

      // Start with no duty: valley pulses at E1, low sides rise at E5.
      en = 1'b1;
      tick();
      chk("e1_ps", 32'(period_start), 32'd1);
      chk("e1_miss", 32'(update_miss), 32'd1);
      chk("e1_al", 32'(pwm_al), 32'd0);
      repeat (3) tick();
      chk("e4_lows", 32'({pwm_al, pwm_bl, pwm_cl}), 32'd0);
      chk("e4_ps", 32'(period_start), 32'd0);
      tick();
      chk("e5_gates", 32'(g), 32'b010101);
      wait_ps("ps_v0", n);
      chk("period_e5_to_e511", 32'(n), 32'd506);
      chk("miss_v0", 32'(update_miss), 32'd1);

      // Load 128/64/192 and keep pending refilled.
      send(8'd128, 8'd64, 8'd192);
      chk("ready_after_load", 32'(duty_ready), 32'd0);
      wait_ps("ps_v1", n);
      chk("period_v1", 32'(n), 32'd509);
      chk("miss_v1", 32'(update_miss), 32'd0);
      chk("ready_v1", 32'(duty_ready), 32'd1);
      send(8'd128, 8'd64, 8'd192);
      wait_ps("ps_v2", n);
      chk("miss_v2", 32'(update_miss), 32'd0);
      send(8'd128, 8'd64, 8'd192);
      measure();
      chk("cnt_ah", 32'(hi_cnt[5]), 32'd251);
      chk("cnt_al", 32'(hi_cnt[4]), 32'd251);
      chk("cnt_bh", 32'(hi_cnt[3]), 32'd123);
      chk("cnt_bl", 32'(hi_cnt[2]), 32'd379);
      chk("cnt_ch", 32'(hi_cnt[1]), 32'd379);
      chk("cnt_cl", 32'(hi_cnt[0]), 32'd123);
      chk("overlap_mid", 32'(overlap), 32'd0);

      // Two transfers in one period: second waits for the valley.
      chk("ready_before_pair", 32'(duty_ready), 32'd1);
      da_on = 8'd10; db_on = 8'd20; dc_on = 8'd30;
      duty_valid = 1'b1;
      tick();
      chk("ready_after_first", 32'(duty_ready), 32'd0);
      da_on = 8'd1; db_on = 8'd255; dc_on = 8'd0;
      n = 0;
      ready_low = 1'b1;
      do begin
         tick();
         n++;
         if (period_start !== 1'b1 && duty_ready !== 1'b0) ready_low = 1'b0;
      end while (period_start !== 1'b1 && n < 600);
      chk("ps_v4", 32'(period_start), 32'd1);
      chk("ready_held_low", 32'(ready_low), 32'd1);
      chk("ready_at_valley", 32'(duty_ready), 32'd1);
      tick();
      chk("ready_second_taken", 32'(duty_ready), 32'd0);
      duty_valid = 1'b0;
      wait_ps("ps_v5", n);
      chk("miss_v5", 32'(update_miss), 32'd0);
      wait_ps("ps_v6", n);
      chk("miss_v6", 32'(update_miss), 32'd1);
      measure();
      chk("edge_ah", 32'(hi_cnt[5]), 32'd0);
      chk("edge_al", 32'(hi_cnt[4]), 32'd505);
      chk("edge_bh", 32'(hi_cnt[3]), 32'd505);
      chk("edge_bl", 32'(hi_cnt[2]), 32'd0);
      chk("edge_ch", 32'(hi_cnt[1]), 32'd0);
      chk("edge_cl", 32'(hi_cnt[0]), 32'd510);
      chk("overlap_edge", 32'(overlap), 32'd0);
      chk("ps_v7", 32'(period_start), 32'd1);

      // Disable at cnt=100 (cnt=1 at the ps sample), handshake still live.
      repeat (99) tick();
      chk("pre_disable_gates", 32'(g), 32'b011001);
      en = 1'b0;
      tick();
      chk("disable_gates", 32'(g), 32'd0);
      chk("disable_ps", 32'(period_start), 32'd0);
      send(8'd128, 8'd64, 8'd192);
      chk("disable_ready", 32'(duty_ready), 32'd0);
      chk("disable_miss", 32'(update_miss), 32'd0);
      repeat (5) tick();
      chk("disable_gates_hold", 32'(g), 32'd0);
      en = 1'b1;
      tick();
      chk("reen_ps", 32'(period_start), 32'd1);
      chk("reen_miss", 32'(update_miss), 32'd0);
      chk("reen_ready", 32'(duty_ready), 32'd1);
      repeat (4) tick();
      chk("reen_e5_ah", 32'(pwm_ah), 32'd0);
      tick();
      chk("reen_e6_ab", 32'({pwm_ah, pwm_al, pwm_bh, pwm_bl}), 32'b1010);

      // Asynchronous reset with pending full mid-period.
      send(8'd50, 8'd50, 8'd50);
      chk("pre_rst_ready", 32'(duty_ready), 32'd0);
      repeat (20) tick();
      chk("pre_rst_ah", 32'(pwm_ah), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_gates", 32'(g), 32'd0);
      chk("async_ready", 32'(duty_ready), 32'd1);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_ps", 32'(period_start), 32'd1);
      chk("post_rst_miss", 32'(update_miss), 32'd1);
      repeat (4) tick();
      chk("post_rst_e5", 32'(g), 32'b010101);
      repeat (100) tick();
      chk("post_rst_active0", 32'(g), 32'b010101);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
